// File: rtl/mlaccel_memory_burst_if.sv
// Client-side bundle of the burst sequencer: command, write beats, read return and status.
interface mlaccel_memory_burst_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [16:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_strb, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_strb, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );
endinterface

// File: rtl/mlaccel_memory_burst.sv
// Burst sequencer in front of mlaccel_memory: one command becomes a run of word accesses,
// read data returns through a credit-checked FIFO that covers the fixed memory latency.
module mlaccel_memory_burst #(
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mlaccel_memory_burst_if.slave bus,
  output logic [16:0]          mem_addr,
  output logic [3:0]           mem_wen,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

  state_t                state;
  logic [16:0]           cur_addr;
  logic [15:0]           remaining;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic                  done_q;

  logic [CW:0] inflight_n;
  logic        credit_ok, rd_issue, wr_fire, push, pop;
  logic [16:0] addr_next;

  // Credits count both stored words and words still in the memory pipe, so a push never overflows.
  always_comb begin
    inflight_n = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight_n = inflight_n + {{CW{1'b0}}, vld_pipe[i]};
    credit_ok = ({1'b0, fifo_cnt} + inflight_n) < (CW+1)'(FIFO_DEPTH);
    rd_issue  = (state == READ) && (remaining != '0) && credit_ok;
    wr_fire   = (state == WRITE) && bus.wr_valid && !reset;
    push      = vld_pipe[RD_LATENCY-1];
    pop       = (fifo_cnt != '0) && bus.rd_ready;
    addr_next = cur_addr + 17'd4;
  end

  assign mem_addr      = cur_addr;
  assign mem_wen       = wr_fire ? bus.wr_strb : 4'h0;
  assign mem_wdata     = bus.wr_data;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.rd_valid  = (fifo_cnt != '0);
  assign bus.rd_data   = fifo_mem[rd_ptr];
  assign bus.busy      = (state != IDLE) || (vld_pipe != '0);
  assign bus.done      = done_q;

  always_ff @(posedge clock)
    if (push) fifo_mem[wr_ptr] <= mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      vld_pipe  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(rd_issue);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case (state)
        IDLE: if (bus.cmd_valid) begin
          cur_addr  <= bus.cmd_addr;
          remaining <= bus.cmd_len;
          if (bus.cmd_len == '0) done_q <= 1'b1;
          else state <= bus.cmd_write ? WRITE : READ;
        end
        WRITE: if (wr_fire) begin
          cur_addr  <= addr_next;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        READ: if (rd_issue) begin
          cur_addr  <= addr_next;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= DRAIN;
        end
        DRAIN: if (vld_pipe == '0) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mlaccel_memory_burst.sv
// Directed plus randomized bench: a word memory with 2-cycle read latency, and a shadow
// memory updated from command semantics that predicts every read word and write access.
module tb_mlaccel_memory_burst;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mlaccel_memory_burst_if bus();
  logic [16:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata, mem_rdata;

  mlaccel_memory_burst dut (
    .clock(clock), .reset(reset), .bus(bus),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] sim_mem [32768];
  logic [31:0] ref_mem [32768];
  logic [31:0] rd_q1;

  always @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) sim_mem[mem_addr[16:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    rd_q1     <= sim_mem[mem_addr[16:2]];
    mem_rdata <= rd_q1;
  end

  int          done_cnt = 0;
  logic [31:0] rd_got [$];
  logic [52:0] wr_log [$];

  always @(negedge clock) begin
    if (bus.done) done_cnt++;
    if (bus.rd_valid && bus.rd_ready) rd_got.push_back(bus.rd_data);
    if (mem_wen != 4'h0) wr_log.push_back({mem_addr, mem_wen, mem_wdata});
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wdat [16];
  logic [3:0]  wstrb [16];
  int d0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [16:0] wrap_addr(input logic [16:0] base, input int i);
    logic [16:0] a;
    a = base + 17'(4 * i);
    return a;
  endfunction

  task automatic send_cmd(input logic w, input logic [16:0] a, input logic [15:0] len);
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 300) begin tick(); k++; end
    if (!bus.cmd_ready) chk("cmd_ready_timeout", 0, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int want_rd, input bit thr);
    int k;
    k = 0;
    while ((done_cnt <= start || rd_got.size() < want_rd) && k < 3000) begin
      bus.rd_ready = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      k++;
    end
    bus.rd_ready = 1'b1;
    if (k >= 3000) chk("burst_timeout", 0, 1);
  endtask

  task automatic start_read(input logic [16:0] a, input logic [15:0] len);
    rd_got.delete();
    d0 = done_cnt;
    send_cmd(1'b0, a, len);
  endtask

  task automatic finish_read(input string tag, input logic [16:0] a, input int len, input bit thr);
    wait_done(d0, len, thr);
    tick(); tick();
    chk({tag, "_count"}, rd_got.size(), len);
    chk({tag, "_done"}, done_cnt - d0, 1);
    for (int i = 0; i < len && i < rd_got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), rd_got[i], ref_mem[wrap_addr(a, i) >> 2]);
  endtask

  task automatic do_write(input string tag, input logic [16:0] a, input int len);
    logic [52:0] exp_log [$];
    logic [16:0] ba;
    int k;
    wr_log.delete();
    d0 = done_cnt;
    send_cmd(1'b1, a, 16'(len));
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin bus.wr_valid = 1'b0; tick(); end
      bus.wr_valid = 1'b1;
      bus.wr_data  = wdat[i];
      bus.wr_strb  = wstrb[i];
      k = 0;
      while (!bus.wr_ready && k < 100) begin tick(); k++; end
      if (!bus.wr_ready) chk({tag, "_wr_ready_timeout"}, 0, 1);
      tick();
      ba = wrap_addr(a, i);
      exp_log.push_back({ba, wstrb[i], wdat[i]});
      for (int b = 0; b < 4; b++)
        if (wstrb[i][b]) ref_mem[ba >> 2][8*b +: 8] = wdat[i][8*b +: 8];
    end
    bus.wr_valid = 1'b0;
    wait_done(d0, 0, 1'b0);
    tick();
    chk({tag, "_nacc"}, wr_log.size(), exp_log.size());
    chk({tag, "_done"}, done_cnt - d0, 1);
    for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
      chk($sformatf("%s_acc%0d", tag, i), wr_log[i], exp_log[i]);
  endtask

  initial begin
    logic [31:0] v;
    logic [16:0] ra;
    int rl;
    for (int i = 0; i < 32768; i++) begin
      v = $urandom;
      sim_mem[i] = v;
      ref_mem[i] = v;
    end
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_strb = '0; bus.rd_ready = 1'b1;

    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_wen", mem_wen, 0);

    // Back-to-back issue and first-word latency
    start_read(17'h00010, 16'd4);
    chk("t1_addr0", mem_addr, 17'h10);
    chk("t1_busy", bus.busy, 1);
    tick(); chk("t1_addr1", mem_addr, 17'h14);
    tick(); chk("t1_addr2", mem_addr, 17'h18);
    chk("t1_rd_valid_early", bus.rd_valid, 0);
    tick(); chk("t1_addr3", mem_addr, 17'h1C);
    chk("t1_rd_valid_lat", bus.rd_valid, 1);
    finish_read("t1", 17'h00010, 4, 1'b0);

    wdat[0] = 32'hA1B2C3D4; wstrb[0] = 4'hF;
    wdat[1] = 32'h11223344; wstrb[1] = 4'hF;
    do_write("t2w", 17'h00003, 2);
    start_read(17'h00003, 16'd2);
    finish_read("t2r", 17'h00003, 2, 1'b0);
    if (rd_got.size() == 2) begin
      chk("t2_word0", rd_got[0], 32'hA1B2C3D4);
      chk("t2_word1", rd_got[1], 32'h11223344);
    end else chk("t2_readback_size", rd_got.size(), 2);

    // Backpressure: four credits exhausted, issue must stall
    ra = 17'($urandom) & 17'h0FFFF;
    bus.rd_ready = 1'b0;
    start_read(ra, 16'd16);
    for (int i = 0; i < 9; i++) tick();
    chk("t3_stall_addr", mem_addr, wrap_addr(ra, 4));
    chk("t3_rd_valid", bus.rd_valid, 1);
    chk("t3_none_popped", rd_got.size(), 0);
    finish_read("t3", ra, 16, 1'b0);

    start_read(17'h1FFFC, 16'd2);
    chk("t4_addr0", mem_addr, 17'h1FFFC);
    tick(); chk("t4_addr_wrap", mem_addr, 17'h00000);
    finish_read("t4", 17'h1FFFC, 2, 1'b0);

    wr_log.delete();
    d0 = done_cnt;
    send_cmd(1'b1, 17'h00040, 16'd0);
    chk("t5w_done", bus.done, 1);
    chk("t5w_cmd_ready", bus.cmd_ready, 1);
    tick(); tick(); tick();
    chk("t5w_no_wen", wr_log.size(), 0);
    chk("t5w_one_done", done_cnt - d0, 1);
    rd_got.delete();
    d0 = done_cnt;
    send_cmd(1'b0, 17'h00040, 16'd0);
    chk("t5r_done", bus.done, 1);
    tick(); tick(); tick(); tick();
    chk("t5r_no_rd", rd_got.size(), 0);
    chk("t5r_rd_valid", bus.rd_valid, 0);
    chk("t5r_one_done", done_cnt - d0, 1);

    // Reset on the third issued beat
    start_read(17'h00200, 16'd8);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_cmd_ready", bus.cmd_ready, 1);
    chk("t6_rd_valid", bus.rd_valid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_no_data", rd_got.size(), 0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 17'h1FFF0 + 17'($urandom_range(0, 15));
      else ra = 17'($urandom);
      rl = $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wdat[i]  = $urandom;
          wstrb[i] = 4'($urandom_range(1, 15));
        end
        do_write($sformatf("rnd%0d_w", n), ra, rl);
      end else begin
        start_read(ra, 16'(rl));
        finish_read($sformatf("rnd%0d_r", n), ra, rl, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
